updn_counter_param: RTL

- Parametrised successor to the team's 4-bit up/down counter.
- Adds configurable width and modulus, count enable, parallel load, and three end-of-range modes: wrap, saturate and one-shot.
- Adds terminal-count flags, a registered wrap/limit event pulse and a sticky overflow flag.
- Used as a general-purpose event/position counter and as a timer base in datapath control blocks.

---
 rtl/updn_counter_pkg.sv | 22 ++
 rtl/updn_counter_param.sv | 106 ++++++++++
 2 files changed

// File: rtl/updn_counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_*        : end-of-range behaviour encodings
//   params_legal  : elaboration-time legality check for WIDTH / MAX_VAL / MODE
package updn_counter_pkg;

   localparam int unsigned MODE_WRAP    = 0;
   localparam int unsigned MODE_SAT     = 1;
   localparam int unsigned MODE_ONESHOT = 2;

   localparam int unsigned MAX_WIDTH = 32;

   // True when the parameter set describes a buildable counter.
   function automatic bit params_legal(input int unsigned     width,
                                       input longint unsigned max_val,
                                       input int unsigned     mode);
      longint unsigned full_range;
      if ((width < 1) || (width > MAX_WIDTH)) return 1'b0;
      full_range = (64'd1 << width) - 64'd1;
      return (max_val >= 64'd1) && (max_val <= full_range) && (mode <= MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with load, enable and wrap/saturate/one-shot ends.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   en, dir        : count enable, direction (1 = up)
//   load, load_val : parallel load strobe and value (clamped to MAX_VAL)
//   clr_ovf        : clears the sticky overflow flag
//   count          : registered count value
//   tc_up, tc_dn   : combinational decode of count == MAX_VAL / count == 0
//   evt            : registered one-cycle pulse on a boundary step
//   ovf            : sticky flag, set on any step attempted past a range end
//   done           : one-shot mode only, counter halted at a terminal value
module updn_counter_param
   import updn_counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     MODE    = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc_up,
   output logic             tc_dn,
   output logic             evt,
   output logic             ovf,
   output logic             done
);

   // Stop elaboration on an unbuildable parameter set.
   if (!params_legal(WIDTH, MAX_VAL, MODE)) begin : g_illegal_params
      $error("updn_counter_param: illegal WIDTH/MAX_VAL/MODE combination");
   end

   localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_VAL);
   localparam bit               IS_WRAP   = (MODE == MODE_WRAP);
   localparam bit               IS_ONESHT = (MODE == MODE_ONESHOT);

   logic [WIDTH-1:0] count_q, count_d;
   logic             evt_q, evt_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             step_hit;

   // Next count: load beats step; a step past either end is flagged as step_hit.
   always_comb begin : next_count
      count_d  = count_q;
      step_hit = 1'b0;
      if (load) begin
         count_d = (load_val > MAX_W) ? MAX_W : load_val;
      end else if (en && !done_q) begin
         if (dir) begin
            if (count_q < MAX_W) begin
               count_d = count_q + WIDTH'(1);
            end else begin
               step_hit = 1'b1;
               if (IS_WRAP) count_d = '0;
            end
         end else begin
            if (count_q > '0) begin
               count_d = count_q - WIDTH'(1);
            end else begin
               step_hit = 1'b1;
               if (IS_WRAP) count_d = MAX_W;
            end
         end
      end
   end

   // Flags: a new overflow wins over clr_ovf in the same cycle.
   always_comb begin : next_flags
      evt_d  = step_hit;
      ovf_d  = step_hit | (ovf_q & ~clr_ovf);
      done_d = done_q;
      if (load) begin
         done_d = 1'b0;
      end else if (step_hit && IS_ONESHT) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         count_q <= '0;
         evt_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         evt_q   <= evt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign evt   = evt_q;
   assign ovf   = ovf_q;
   assign done  = done_q;
   assign tc_up = (count_q == MAX_W);
   assign tc_dn = (count_q == '0);

endmodule
